one_wire_slave: RTL

- 1-Wire responder (slave) for the FPGA; it is the bus-side counterpart of the existing 1-Wire master.
- Detects master reset pulses and answers each with a presence pulse.
- Receives bytes written by the master (LSB first).
- Transmits a host-armed byte during master read slots.
- Uses the same open-drain convention as the master: oneWireRx=1 means bus LOW, oneWireTx=1 pulls bus LOW.

---
 rtl/one_wire_slave_if.sv | 27 ++
 rtl/one_wire_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_slave_if.sv
// Bundle of the host-side handshake and 1-Wire bus lines of the responder.
// The slave modport is the responder's view; master is the host/bus-model view.
interface one_wire_slave_if;
  logic [7:0] txData;
  logic       txLoad;
  logic [7:0] rxData;
  logic       rxValid;
  logic       txBusy;
  logic       txDone;
  logic       resetDetected;
  logic       presenceDone;
  logic [7:0] crcValue;
  logic       oneWireRx;
  logic       oneWireTx;

  modport slave (
    input  txData, txLoad, oneWireRx,
    output rxData, rxValid, txBusy, txDone, resetDetected, presenceDone,
           crcValue, oneWireTx
  );

  modport master (
    output txData, txLoad, oneWireRx,
    input  rxData, rxValid, txBusy, txDone, resetDetected, presenceDone,
           crcValue, oneWireTx
  );
endinterface

// File: rtl/one_wire_slave.sv
// 1-Wire responder: reset/presence handling, LSB-first byte receive and armed byte transmit.
// Define ONE_WIRE_SLAVE_CRC_EN to add a running Dallas CRC8 on crcValue (otherwise it reads 0x00).
module one_wire_slave #(
  parameter int CLK_FRQ_MHZ      = 24,
  parameter int RESET_MIN_US     = 400,
  parameter int PRESENCE_WAIT_US = 30,
  parameter int PRESENCE_LEN_US  = 120,
  parameter int SAMPLE_US        = 30,
  parameter int HOLD_US          = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable_i,
  one_wire_slave_if.slave bus
);

  localparam int               PRE_W    = (CLK_FRQ_MHZ > 1) ? $clog2(CLK_FRQ_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_FRQ_MHZ - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [10:0]      US_MAX   = 11'h7FF;
  localparam logic [10:0]      T_RESET  = 11'(RESET_MIN_US);
  localparam logic [10:0]      T_PWAIT  = 11'(PRESENCE_WAIT_US);
  localparam logic [10:0]      T_PLEN   = 11'(PRESENCE_LEN_US);
  localparam logic [10:0]      T_SAMPLE = 11'(SAMPLE_US);
  localparam logic [10:0]      T_HOLD   = 11'(HOLD_US);

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    PRES_WAIT,
    PRES_DRIVE,
    SLOT_START,
    SLOT_DRIVE,
    SLOT_SAMPLE,
    SLOT_END
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             busLow_q;
  logic             busLowDly_q;
  logic [PRE_W-1:0] preCnt_q;
  logic [PRE_W-1:0] preCnt_d;
  logic [10:0]      usCnt_q;
  logic [10:0]      usCnt_d;
  logic [2:0]       bitCnt_q;
  logic [7:0]       rxShift_q;
  logic [7:0]       rxData_q;
  logic [7:0]       txShift_q;
  logic             txArmed_q;
  logic             oneWireTx_q;
  logic             rxValid_q;
  logic             txDone_q;
  logic             resetDet_q;
  logic             presDone_q;

  logic             usTick;
  logic             fall;
  logic             inPres;
  logic             wdFire;

  // Our own presence pull also looks like a fall, so PRES_* ignores falls and the watchdog.
  always_comb begin
    usTick   = (preCnt_q == PRE_MAX);
    preCnt_d = usTick ? '0 : preCnt_q + PRE_ONE;
    usCnt_d  = (usTick && (usCnt_q != US_MAX)) ? usCnt_q + 11'd1 : usCnt_q;
    fall     = busLow_q & ~busLowDly_q;
    inPres   = (state_q == PRES_WAIT) || (state_q == PRES_DRIVE);
    wdFire   = busLow_q && !inPres && (usCnt_q >= T_RESET);
  end

`ifdef ONE_WIRE_SLAVE_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       slotBit;

  always_comb begin
    slotBit = txArmed_q ? txShift_q[0] : rxShift_q[7];
    crc_d   = {1'b0, crc_q[7:1]} ^ (((crc_q[0] ^ slotBit) == 1'b1) ? 8'h8C : 8'h00);
  end

  assign bus.crcValue = crc_q;
`else
  assign bus.crcValue = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      busLow_q    <= 1'b0;
      busLowDly_q <= 1'b0;
      preCnt_q    <= '0;
      usCnt_q     <= '0;
      bitCnt_q    <= '0;
      rxShift_q   <= '0;
      rxData_q    <= '0;
      txShift_q   <= '0;
      txArmed_q   <= 1'b0;
      oneWireTx_q <= 1'b0;
      rxValid_q   <= 1'b0;
      txDone_q    <= 1'b0;
      resetDet_q  <= 1'b0;
      presDone_q  <= 1'b0;
`ifdef ONE_WIRE_SLAVE_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      sync1_q     <= bus.oneWireRx;
      busLow_q    <= sync1_q;
      busLowDly_q <= busLow_q;
      rxValid_q   <= 1'b0;
      txDone_q    <= 1'b0;
      resetDet_q  <= 1'b0;
      presDone_q  <= 1'b0;
      preCnt_q    <= preCnt_d;
      usCnt_q     <= usCnt_d;

      if (!enable_i) begin
        state_q     <= IDLE;
        preCnt_q    <= '0;
        usCnt_q     <= '0;
        bitCnt_q    <= '0;
        txArmed_q   <= 1'b0;
        oneWireTx_q <= 1'b0;
      end else if (wdFire) begin
        state_q     <= RST_LOW;
        preCnt_q    <= '0;
        usCnt_q     <= '0;
        bitCnt_q    <= '0;
        txArmed_q   <= 1'b0;
        oneWireTx_q <= 1'b0;
        resetDet_q  <= 1'b1;
`ifdef ONE_WIRE_SLAVE_CRC_EN
        crc_q       <= '0;
`endif
      end else begin
        if (fall && !inPres) begin
          preCnt_q <= '0;
          usCnt_q  <= '0;
        end

        // Every state change below also restarts the microsecond timebase.
        case (state_q)
          IDLE: begin
            if (bus.txLoad && (bitCnt_q == 3'd0)) begin
              txArmed_q <= 1'b1;
              txShift_q <= bus.txData;
            end
            if (fall) begin
              state_q  <= SLOT_START;
              preCnt_q <= '0;
              usCnt_q  <= '0;
            end
          end

          RST_LOW: begin
            if (!busLow_q) begin
              state_q  <= PRES_WAIT;
              preCnt_q <= '0;
              usCnt_q  <= '0;
            end
          end

          PRES_WAIT: begin
            if (usCnt_q >= T_PWAIT) begin
              state_q     <= PRES_DRIVE;
              oneWireTx_q <= 1'b1;
              preCnt_q    <= '0;
              usCnt_q     <= '0;
            end
          end

          PRES_DRIVE: begin
            if (usCnt_q >= T_PLEN) begin
              state_q     <= IDLE;
              oneWireTx_q <= 1'b0;
              presDone_q  <= 1'b1;
              preCnt_q    <= '0;
              usCnt_q     <= '0;
            end
          end

          SLOT_START: begin
            preCnt_q <= '0;
            usCnt_q  <= '0;
            if (!txArmed_q) begin
              state_q <= SLOT_SAMPLE;
            end else if (!txShift_q[0]) begin
              state_q     <= SLOT_DRIVE;
              oneWireTx_q <= 1'b1;
            end else begin
              state_q <= SLOT_END;
            end
          end

          SLOT_DRIVE: begin
            if (usCnt_q >= T_HOLD) begin
              state_q     <= SLOT_END;
              oneWireTx_q <= 1'b0;
              preCnt_q    <= '0;
              usCnt_q     <= '0;
            end
          end

          SLOT_SAMPLE: begin
            if (usCnt_q >= T_SAMPLE) begin
              rxShift_q <= {~busLow_q, rxShift_q[7:1]};
              state_q   <= SLOT_END;
              preCnt_q  <= '0;
              usCnt_q   <= '0;
            end
          end

          SLOT_END: begin
            if (!busLow_q) begin
              bitCnt_q <= bitCnt_q + 3'd1;
`ifdef ONE_WIRE_SLAVE_CRC_EN
              crc_q    <= crc_d;
`endif
              if (txArmed_q) begin
                txShift_q <= {1'b0, txShift_q[7:1]};
                if (bitCnt_q == 3'd7) begin
                  txArmed_q <= 1'b0;
                  txDone_q  <= 1'b1;
                end
              end else if (bitCnt_q == 3'd7) begin
                rxData_q  <= rxShift_q;
                rxValid_q <= 1'b1;
              end
              state_q  <= IDLE;
              preCnt_q <= '0;
              usCnt_q  <= '0;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rxData        = rxData_q;
  assign bus.rxValid       = rxValid_q;
  assign bus.txBusy        = txArmed_q;
  assign bus.txDone        = txDone_q;
  assign bus.resetDetected = resetDet_q;
  assign bus.presenceDone  = presDone_q;
  assign bus.oneWireTx     = oneWireTx_q;

endmodule
